dlx_alu_ctrl: RTL and testbench
===============================

Name: dlx_alu_ctrl

Overview:
- Multicycle issue/writeback controller directly upstream of the DLX ALU stage.
- Accepts DLX R-type and I-type ALU instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 32x32 register file and drives the ALU opcode, operands and execute strobe.
- Writes the ALU's registered result back to the destination register.

Parameters:
RF_RESET, 1, 1 = register file cleared to 0 on reset; 0 = contents retained (r0 still reads 0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction word valid
instr  in  32  DLX instruction word
instr_ready  out  1  controller can accept an instruction (IDLE only)
alu_I  out  4  ALU opcode (1..13 encoding)
alu_EX  out  1  ALU capture enable, one-cycle pulse
alu_op1  out  32  ALU operand 1
alu_op2  out  32  ALU operand 2
alu_res  in  32  ALU registered result; valid the cycle after alu_EX
dbg_addr  in  5  register file debug read address
dbg_data  out  32  combinational read of register dbg_addr
done  out  1  one-cycle pulse in the WB cycle
illegal  out  1  one-cycle pulse: unsupported instruction dropped

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE; alu_I=0, alu_EX=0, alu_op1=0, alu_op2=0, done=0, illegal=0.
  - Registers cleared if RF_RESET=1.
  - instr_ready=1 after reset deasserts.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid&instr_ready at an edge, latch instr and go to DECODE.
  - DECODE:
    - Legal instruction: register alu_I, alu_op1, alu_op2 at the cycle end, latch rd, go to EXEC.
    - Illegal instruction: illegal=1 this cycle, no operand update, go to IDLE.
  - EXEC: alu_EX=1 for exactly this cycle; I/op1/op2 held stable. Go to WB.
  - WB:
    - done=1.
    - At the cycle end, write alu_res to rd unless rd==0. Go to IDLE.
- Latency: accept edge T0 → DECODE cycle 1 → EXEC cycle 2 → WB cycle 3 → instr_ready=1 in cycle 4.
  - Throughput: one instruction per 4 cycles.
  - Illegal instruction: ready again in cycle 2.
- alu_I, alu_op1, alu_op2 hold their last values outside DECODE updates.
- R-type (opcode[31:26]=0): rs1=[25:21], rs2=[20:16], rd=[15:11], func=[5:0].
  - op1=R[rs1], op2=R[rs2].
  - func→I mapping: 0x20→1, 0x22→2, 0x24→3, 0x25→4, 0x26→5, 0x04→6, 0x06→7, 0x28→10, 0x2C→11, 0x2A→12, 0x29→13.
  - Any other func is illegal.
- I-type: rs1=[25:21], rd=[20:16], imm=[15:0]; op1=R[rs1].
  - Sign-extended imm: opcode 0x08→1, 0x0A→2, 0x18→10, 0x1C→11, 0x1A→12, 0x19→13.
  - Zero-extended imm: opcode 0x0C→3, 0x0D→4, 0x0E→5, 0x14→6, 0x16→7.
  - Any other opcode is illegal.
- Register file:
  - r0 always reads 0; writes to r0 are discarded (EXEC and done still occur).
  - Reads occur in DECODE.
  - No bypass is needed, since WB completes before the next DECODE.
  - dbg_data shows the pre-write value during the WB cycle and the new value from the next cycle.
- Handshake:
  - instr is sampled only on the accepting edge.
  - instr_valid while busy is ignored (not queued).
  - instr may change freely after acceptance.
- Reset mid-operation (any state): immediate return to IDLE.
  - alu_EX, done and illegal drop asynchronously.
  - Any pending writeback is discarded.

Test Plan:
1. Reset, then ADDI r1,r0,5 (0x20010005) → cycle 2: alu_EX=1, alu_I=1, op1=0, op2=5; cycle 3: done=1; cycle 4: dbg r1=0x00000005, instr_ready=1.
2. ADDI r2,r0,-3 (0x2002FFFD) → op2=0xFFFFFFFD; r2=0xFFFFFFFD. Then ANDI r3,r2,0xFFFF (0x3043FFFF) → alu_I=3, op2=0x0000FFFF; r3=0x0000FFFD.
3. With r1=5, r2=0xFFFFFFFD: SUB r4,r1,r2 (0x00222022) → alu_I=2, op1=5, op2=0xFFFFFFFD; r4=0x00000008.
4. ADDI r0,r0,7 (0x20000007) → alu_EX pulse and done pulse occur; dbg r0 stays 0.
5. Opcode 0x3F (0xFC000000) and R-type func 0x3F → illegal=1 in cycle 1, alu_EX never asserts, no register changes, instr_ready=1 in cycle 2. Also hold instr_valid=1 continuously → exactly one acceptance per 4 cycles.
6. Assert rst_n=0 during EXEC of ADDI r5,r0,9 → alu_EX drops immediately, state IDLE, r5=0 (RF_RESET=1), instr_ready=1 after release.

Source files
------------

// File: rtl/dlx_alu_ctrl.sv
// Issue/writeback controller in front of the DLX ALU: decodes R/I-type ALU
// instructions, reads operands from a 32x32 register file and writes results back.
module dlx_alu_ctrl #(
  parameter bit RF_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  output logic [3:0]  alu_I_o,
  output logic        alu_EX_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  input  logic [31:0] alu_res_i,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o,
  output logic        done_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [4:0]  rd_q;
  logic [3:0]  alu_I_q;
  logic [31:0] op1_q, op2_q;
  logic [31:0] rf_q [32];

  logic        accept;
  logic        is_rtype;
  logic [5:0]  opcode, func;
  logic [4:0]  rs1, rs2, rd_d;
  logic [15:0] imm;
  logic        dec_legal;
  logic        dec_zext;
  logic [3:0]  dec_op;
  logic [31:0] rs1_val, rs2_val, imm_ext;
  logic [31:0] op1_d, op2_d;
  logic        rf_we;

  assign opcode   = instr_q[31:26];
  assign func     = instr_q[5:0];
  assign rs1      = instr_q[25:21];
  assign rs2      = instr_q[20:16];
  assign imm      = instr_q[15:0];
  assign is_rtype = (opcode == 6'h00);
  assign rd_d     = is_rtype ? instr_q[15:11] : instr_q[20:16];

  assign accept   = instr_valid_i && instr_ready_o;

  // r0 is hardwired to zero on every read port regardless of array contents.
  assign rs1_val    = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val    = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'd0 : rf_q[dbg_addr_i];

  assign imm_ext = dec_zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign op1_d   = rs1_val;
  assign op2_d   = is_rtype ? rs2_val : imm_ext;

  always_comb begin
    dec_legal = 1'b0;
    dec_zext  = 1'b0;
    dec_op    = 4'd0;
    if (is_rtype) begin
      dec_legal = 1'b1;
      case (func)
        6'h20:   dec_op = 4'd1;
        6'h22:   dec_op = 4'd2;
        6'h24:   dec_op = 4'd3;
        6'h25:   dec_op = 4'd4;
        6'h26:   dec_op = 4'd5;
        6'h04:   dec_op = 4'd6;
        6'h06:   dec_op = 4'd7;
        6'h28:   dec_op = 4'd10;
        6'h2C:   dec_op = 4'd11;
        6'h2A:   dec_op = 4'd12;
        6'h29:   dec_op = 4'd13;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b1;
      case (opcode)
        6'h08:   dec_op = 4'd1;
        6'h0A:   dec_op = 4'd2;
        6'h18:   dec_op = 4'd10;
        6'h1C:   dec_op = 4'd11;
        6'h1A:   dec_op = 4'd12;
        6'h19:   dec_op = 4'd13;
        6'h0C:   begin dec_op = 4'd3; dec_zext = 1'b1; end
        6'h0D:   begin dec_op = 4'd4; dec_zext = 1'b1; end
        6'h0E:   begin dec_op = 4'd5; dec_zext = 1'b1; end
        6'h14:   begin dec_op = 4'd6; dec_zext = 1'b1; end
        6'h16:   begin dec_op = 4'd7; dec_zext = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DECODE;
      DECODE:  state_d = dec_legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state so that reset removes them asynchronously.
  always_comb begin
    instr_ready_o = (state_q == IDLE) && rst_n_i;
    alu_EX_o      = (state_q == EXEC);
    done_o        = (state_q == WB);
    illegal_o     = (state_q == DECODE) && !dec_legal;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q <= 32'd0;
      rd_q    <= 5'd0;
      alu_I_q <= 4'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
    end else begin
      if (accept) instr_q <= instr_i;
      if ((state_q == DECODE) && dec_legal) begin
        rd_q    <= rd_d;
        alu_I_q <= dec_op;
        op1_q   <= op1_d;
        op2_q   <= op2_d;
      end
    end
  end

  assign alu_I_o   = alu_I_q;
  assign alu_op1_o = op1_q;
  assign alu_op2_o = op2_q;

  assign rf_we = (state_q == WB) && (rd_q != 5'd0);

  generate
    if (RF_RESET) begin : g_rf_reset
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we) begin
          rf_q[rd_q] <= alu_res_i;
        end
      end
    end else begin : g_rf_noreset
      always_ff @(posedge clk_i) begin
        if (rf_we) rf_q[rd_q] <= alu_res_i;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dlx_alu_ctrl.sv
// Self-checking bench for dlx_alu_ctrl: directed plan steps plus randomized
// instructions compared against a table-driven reference model and a behavioural ALU.
module tb_dlx_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        ready;
  logic [3:0]  alu_I;
  logic        alu_EX;
  logic [31:0] op1, op2;
  logic [31:0] alu_res = 32'd0;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] mrf [32];
  int          rTab [64];
  int          iTab [64];
  bit          iZext [64];
  int          rFuncs [11] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h04, 'h06, 'h28, 'h2C, 'h2A, 'h29};
  int          iOps   [11] = '{'h08, 'h0A, 'h18, 'h1C, 'h1A, 'h19, 'h0C, 'h0D, 'h0E, 'h14, 'h16};

  dlx_alu_ctrl #(.RF_RESET(1'b1)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .instr_valid_i(instr_valid),
    .instr_i      (instr),
    .instr_ready_o(ready),
    .alu_I_o      (alu_I),
    .alu_EX_o     (alu_EX),
    .alu_op1_o    (op1),
    .alu_op2_o    (op2),
    .alu_res_i    (alu_res),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data),
    .done_o       (done),
    .illegal_o    (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluFn(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1:       return a + b;
      2:       return a - b;
      3:       return a & b;
      4:       return a | b;
      5:       return a ^ b;
      6:       return a << b[4:0];
      7:       return a >> b[4:0];
      10:      return {31'd0, a == b};
      11:      return {31'd0, $signed(a) <= $signed(b)};
      12:      return {31'd0, $signed(a) < $signed(b)};
      13:      return {31'd0, a != b};
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU: registers its result on the alu_EX edge.
  always @(posedge clk) if (alu_EX) alu_res <= aluFn(int'(alu_I), op1, op2);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelDecode(input logic [31:0] ins, output bit legal, output int opc,
                             output logic [31:0] a, output logic [31:0] b, output logic [4:0] rd);
    int o;
    o = int'(ins[31:26]);
    a = mrf[ins[25:21]];
    if (o == 0) begin
      opc = rTab[ins[5:0]];
      b   = mrf[ins[20:16]];
      rd  = ins[15:11];
    end else begin
      opc = iTab[o];
      b   = iZext[o] ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
      rd  = ins[20:16];
    end
    legal = (opc != 0);
  endtask

  // Issues one instruction from an IDLE negedge and follows it to the next IDLE negedge.
  task automatic applyStimulus(input logic [31:0] ins);
    bit          legal;
    int          opc;
    logic [31:0] a, b, expRes;
    logic [4:0]  rd;
    modelDecode(ins, legal, opc, a, b, rd);
    instr_valid = 1'b1;
    instr       = ins;
    #1 checkOutput("ready_idle", ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    #1;
    checkOutput("illegal_decode", illegal, legal ? 0 : 1);
    checkOutput("ex_in_decode", alu_EX, 0);
    checkOutput("ready_busy", ready, 0);
    if (!legal) begin
      dbg_addr = 5'd1;
      @(negedge clk);
      #1;
      checkOutput("ready_after_illegal", ready, 1);
      checkOutput("illegal_cleared", illegal, 0);
      checkOutput("ex_after_illegal", alu_EX, 0);
      checkOutput("r1_untouched", dbg_data, mrf[1]);
      return;
    end
    @(negedge clk);
    #1;
    checkOutput("ex_pulse", alu_EX, 1);
    checkOutput("alu_I", alu_I, opc);
    checkOutput("alu_op1", op1, a);
    checkOutput("alu_op2", op2, b);
    checkOutput("done_in_exec", done, 0);
    @(negedge clk);
    dbg_addr = rd;
    #1;
    checkOutput("done_pulse", done, 1);
    checkOutput("ex_dropped", alu_EX, 0);
    checkOutput("dbg_prewrite", dbg_data, mrf[rd]);
    expRes = aluFn(opc, a, b);
    if (rd != 5'd0) mrf[rd] = expRes;
    @(negedge clk);
    #1;
    checkOutput("ready_after_wb", ready, 1);
    checkOutput("done_cleared", done, 0);
    checkOutput("dbg_postwrite", dbg_data, mrf[rd]);
    checkOutput("alu_I_held", alu_I, opc);
  endtask

  function automatic logic [31:0] randInstr();
    int          k;
    int          f;
    logic [4:0]  ra, rb, rc;
    k  = $urandom_range(0, 99);
    ra = 5'($urandom_range(0, 7));
    rb = 5'($urandom_range(0, 7));
    rc = 5'($urandom_range(0, 7));
    if (k < 8) begin
      do f = $urandom_range(1, 63); while (iTab[f] != 0);
      return {6'(f), ra, rb, 16'($urandom)};
    end else if (k < 16) begin
      do f = $urandom_range(0, 63); while (rTab[f] != 0);
      return {6'd0, ra, rb, rc, 5'($urandom), 6'(f)};
    end else if (k < 55) begin
      f = rFuncs[$urandom_range(0, 10)];
      return {6'd0, ra, rb, rc, 5'd0, 6'(f)};
    end else begin
      f = iOps[$urandom_range(0, 10)];
      return {6'(f), ra, rc, 16'($urandom)};
    end
  endfunction

  initial begin
    int accepts;
    for (int i = 0; i < 64; i++) begin rTab[i] = 0; iTab[i] = 0; iZext[i] = 1'b0; end
    for (int i = 0; i < 11; i++) begin
      rTab[rFuncs[i]] = (i < 7) ? i + 1 : i + 3;
      iTab[iOps[i]]   = (i < 6) ? ((i < 2) ? i + 1 : i + 8) : i - 3;
      iZext[iOps[i]]  = (i >= 6);
    end
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 5'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_alu_EX", alu_EX, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_alu_I", alu_I, 0);
    checkOutput("rst_op1", op1, 0);
    checkOutput("rst_op2", op2, 0);
    rst_n = 1'b1;
    #1 checkOutput("rst_ready", ready, 1);

    applyStimulus(32'h20010005);
    applyStimulus(32'h2002FFFD);
    applyStimulus(32'h3043FFFF);
    checkOutput("plan_r3", dbg_data, 32'h0000FFFD);
    applyStimulus(32'h00222022);
    checkOutput("plan_r4", dbg_data, 32'h00000008);
    applyStimulus(32'h20000007);
    checkOutput("plan_r0", dbg_data, 32'h0);
    applyStimulus(32'hFC000000);
    applyStimulus(32'h0000003F);

    for (int n = 0; n < 40; n++) applyStimulus(randInstr());

    // Continuous valid: one acceptance every four cycles.
    accepts     = 0;
    instr_valid = 1'b1;
    instr       = 32'h20C60001;
    for (int i = 0; i < 12; i++) begin
      #1 if (ready) accepts++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    mrf[6] = mrf[6] + 32'd3;
    checkOutput("hold_accepts", accepts, 3);
    dbg_addr = 5'd6;
    #1 checkOutput("hold_r6", dbg_data, mrf[6]);

    // Reset during EXEC discards the pending writeback.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 32'h20050009;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1 checkOutput("mid_ex_before", alu_EX, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_ex_dropped", alu_EX, 0);
    checkOutput("mid_done", done, 0);
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    dbg_addr = 5'd5;
    #1;
    checkOutput("mid_ready", ready, 1);
    checkOutput("mid_r5", dbg_data, 32'd0);
    repeat (2) @(negedge clk);
    #1 checkOutput("mid_no_late_done", done, 0);
    checkOutput("mid_r5_after", dbg_data, 32'd0);

    @(negedge clk);
    applyStimulus(32'h20010005);
    for (int n = 0; n < 10; n++) applyStimulus(randInstr());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
